// File: rtl/pve_move_picker_if.sv
// Bus between the game controller (master) and the PvE move picker (slave).
// tokens[r][c] is a 2-bit cell code; row 0 is the top row.
interface pve_move_picker_if #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) ();
    logic [ROWS-1:0][COLS-1:0][1:0] tokens;
    logic                           bot_turn;
    logic [COLS-1:0]                bot_move;
    logic                           bot_confirm;
    logic                           board_full;

    modport master (
        output tokens, bot_turn,
        input  bot_move, bot_confirm, board_full
    );

    modport slave (
        input  tokens, bot_turn,
        output bot_move, bot_confirm, board_full
    );
endinterface

// File: rtl/pve_move_picker.sv
// PvE bot move generator: random legal column from a shared LFSR, centre-out
// tie-break, deterministic fallback after RETRY_MAX empty draws, one-cycle confirm.
module pve_move_picker #(
    parameter int                ROWS        = 6,
    parameter int                COLS        = 7,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] TAPS        = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
    parameter int                RETRY_MAX   = 3,
    parameter int                HOLD_CYCLES = 6250000
) (
    input  logic              clock,
    input  logic              reset,
    pve_move_picker_if.slave  bus
);
    localparam int SEL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int CENTRE  = (COLS - 1) / 2;
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);
    localparam logic [HOLD_W-1:0]  HOLD_LIM  = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, PICK, CONFIRM, HOLD} state_t;

    state_t              state, state_next;
    logic [LFSR_W-1:0]   lfsr;
    logic [RETRY_W-1:0]  retry;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [SEL_W-1:0]    sel;
    logic                board_full_q;
    logic [COLS-1:0]     legal;
    logic [COLS-1:0]     cand;
    logic                unused_rows;

    // Walk the centre-out order backwards so the earliest matching entry wins.
    function automatic logic [SEL_W-1:0] pick(input logic [COLS-1:0] m);
        int              col;
        logic [COLS-1:0] shifted;
        pick = '0;
        for (int i = 2 * COLS - 1; i >= 0; i--) begin
            col     = (i % 2 == 0) ? CENTRE - i / 2 : CENTRE + (i + 1) / 2;
            shifted = m >> col;
            if (col >= 0 && col < COLS && shifted[0]) begin
                pick = SEL_W'(col);
            end
        end
    endfunction

    always_comb begin
        legal = '0;
        for (int c = 0; c < COLS; c++) begin
            legal[c] = (bus.tokens[0][c] == 2'b00);
        end
        cand = legal & lfsr[COLS-1:0];
    end

    assign unused_rows = ^bus.tokens;

    // The LFSR free-runs in every state so each turn sees a fresh mask.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (lfsr == '0) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.bot_turn && (|legal)) state_next = PICK;
            end
            PICK: begin
                if (!bus.bot_turn || !(|legal)) begin
                    state_next = IDLE;
                end else if ((|cand) || retry == RETRY_LIM) begin
                    state_next = CONFIRM;
                end
            end
            CONFIRM: state_next = HOLD;
            HOLD: begin
                if (!bus.bot_turn && hold_cnt == HOLD_LIM) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // hold_cnt saturates at HOLD_LIM, so equality stands in for >=.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retry        <= '0;
            hold_cnt     <= '0;
            sel          <= '0;
            board_full_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.bot_turn) begin
                        if (|legal) begin
                            retry        <= '0;
                            board_full_q <= 1'b0;
                        end else begin
                            board_full_q <= 1'b1;
                        end
                    end
                end
                PICK: begin
                    if (bus.bot_turn && (|legal)) begin
                        if (|cand) begin
                            sel <= pick(cand);
                        end else if (retry == RETRY_LIM) begin
                            sel <= pick(legal);
                        end else begin
                            retry <= retry + RETRY_W'(1);
                        end
                    end
                end
                CONFIRM: hold_cnt <= '0;
                HOLD: begin
                    if (hold_cnt != HOLD_LIM) hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.bot_move    = '0;
        bus.bot_confirm = 1'b0;
        if (state == CONFIRM) begin
            bus.bot_move    = COLS'(1) << sel;
            bus.bot_confirm = 1'b1;
        end
    end

    assign bus.board_full = board_full_q;
endmodule
